// File: rtl/fb_frame_writer.sv
// Frame command consumer: fetches rows from the row buffer and writes them
// into one of two SDRAM framebuffers, swapping buffers on clean frame end.
//
// Ports:
//   clk, reset_n        memory clock, async active-low reset
//   command_data_valid  command present (held until cmd_rdy)
//   command_data        1=FRAME_START 2=ROW_START 3=FRAME_END
//   cmd_rdy             one-cycle accept pulse
//   mem_addr            row-buffer word address
//   pixel_data          row-buffer data, MEM_READ_DELAY after mem_addr
//   wr_en/addr/data     framebuffer word write
//   buffer_sel          buffer being written
//   frame_done          pulse on clean frame completion
//   protocol_error      sticky protocol violation flag
//   row_count           rows completed in the current frame
module fb_frame_writer #(
  parameter int FRAME_WIDTH = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int MEM_READ_DELAY = 6,
  parameter int ADDR_WIDTH = 21,
  parameter logic [ADDR_WIDTH-1:0] BUF1_BASE = 21'h080000,
  localparam int WORDS = FRAME_WIDTH / 2,
  localparam int RA_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  command_data_valid,
  input  logic [1:0]            command_data,
  output logic                  cmd_rdy,
  output logic [RA_W-1:0]       mem_addr,
  input  logic [31:0]           pixel_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  buffer_sel,
  output logic                  frame_done,
  output logic                  protocol_error,
  output logic [10:0]           row_count
);

  localparam int D = MEM_READ_DELAY;
  localparam int DW = $clog2(D + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  localparam logic [1:0] C_FS = 2'd1;
  localparam logic [1:0] C_RS = 2'd2;
  localparam logic [1:0] C_FE = 2'd3;

  logic [2:0]      state;
  logic [D-1:0]    tag;
  logic [RA_W-1:0] wcol;
  logic [DW-1:0]   dcnt;
  logic            take;
  logic            rs_ok;
  logic            fe_ok;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] row_off;

  // cmd_rdy gates acceptance so a held command is never taken twice
  assign take = command_data_valid && !cmd_rdy &&
                (state == S_IDLE || state == S_WAIT);

  assign rs_ok = (command_data == C_RS) &&
                 (row_count < 11'(FRAME_HEIGHT));
  assign fe_ok = (command_data == C_FE) &&
                 (row_count == 11'(FRAME_HEIGHT));

  // tag[D-1] marks the cycle in which the read data returns
  assign wr_en = tag[D-1];

  assign base = buffer_sel ? BUF1_BASE : '0;
  assign row_off = ADDR_WIDTH'(row_count) * ADDR_WIDTH'(WORDS);

  assign wr_addr = wr_en ? (base + row_off + ADDR_WIDTH'(wcol)) : '0;
  assign wr_data = wr_en ? pixel_data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      tag            <= '0;
      wcol           <= '0;
      dcnt           <= '0;
      cmd_rdy        <= 1'b0;
      mem_addr       <= '0;
      buffer_sel     <= 1'b0;
      frame_done     <= 1'b0;
      protocol_error <= 1'b0;
      row_count      <= '0;
    end else begin
      cmd_rdy    <= take;
      frame_done <= 1'b0;
      tag        <= (tag << 1) | D'(state == S_READ);
      if (wr_en) wcol <= wcol + 1'b1;

      case (state)
        S_IDLE: begin
          if (take) begin
            if (command_data == C_FS) state <= S_ACCEPT;
            else protocol_error <= 1'b1;
          end
        end
        S_ACCEPT: begin
          row_count <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (take) begin
            unique case (1'b1)
              rs_ok: begin
                mem_addr <= '0;
                wcol     <= '0;
                state    <= S_READ;
              end
              fe_ok: begin
                frame_done <= 1'b1;
                buffer_sel <= ~buffer_sel;
                state      <= S_IDLE;
              end
              default: begin
                protocol_error <= 1'b1;
                state          <= S_IDLE;
              end
            endcase
          end
        end
        S_READ: begin
          if (mem_addr == RA_W'(WORDS - 1)) begin
            dcnt  <= '0;
            state <= S_DRAIN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (dcnt == DW'(D - 1)) begin
            if (row_count < 11'(FRAME_HEIGHT))
              row_count <= row_count + 11'd1;
            state <= S_WAIT;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_frame_writer.sv
// Testbench for fb_frame_writer: command table plus hand sequences,
// framebuffer writes checked against a scoreboard queue.
module tb_fb_frame_writer;

  localparam int W2 = 320;
  localparam int H = 20;
  localparam int D = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        command_data_valid = 1'b0;
  logic [1:0]  command_data = 2'd0;
  logic        cmd_rdy;
  logic [8:0]  mem_addr;
  logic [31:0] pixel_data;
  logic        wr_en;
  logic [20:0] wr_addr;
  logic [31:0] wr_data;
  logic        buffer_sel;
  logic        frame_done;
  logic        protocol_error;
  logic [10:0] row_count;

  fb_frame_writer #(
    .FRAME_WIDTH(640),
    .FRAME_HEIGHT(H),
    .MEM_READ_DELAY(D),
    .ADDR_WIDTH(21),
    .BUF1_BASE(21'h080000)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .command_data_valid(command_data_valid),
    .command_data(command_data),
    .cmd_rdy(cmd_rdy),
    .mem_addr(mem_addr),
    .pixel_data(pixel_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .buffer_sel(buffer_sel),
    .frame_done(frame_done),
    .protocol_error(protocol_error),
    .row_count(row_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rs_cyc = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ten vertical bars, stamped with the column so shifts are visible
  function automatic logic [31:0] pix(input logic [8:0] k);
    logic [15:0] c;
    int b;
    b = int'(k) / 32;
    case (b)
      0: c = 16'hFFFF;
      1: c = 16'hFFE0;
      2: c = 16'h07FF;
      3: c = 16'h07E0;
      4: c = 16'hF81F;
      5: c = 16'hF800;
      6: c = 16'h001F;
      7: c = 16'h0000;
      8: c = 16'h8410;
      default: c = 16'h4208;
    endcase
    return {c ^ 16'(k) ^ 16'h8000, c ^ 16'(k)};
  endfunction

  // row buffer with fixed read latency
  logic [8:0] pipe [D];
  always @(posedge clk) begin
    pipe[0] <= mem_addr;
    for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
  end
  assign pixel_data = pix(pipe[D-1]);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [20:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  // small reference model of accepted commands
  bit m_frame = 0;
  bit m_sel = 0;
  int m_rows = 0;

  task automatic model_accept(input logic [1:0] code);
    logic [20:0] b;
    if (!m_frame) begin
      if (code == 2'd1) begin
        m_frame = 1;
        m_rows = 0;
      end
    end else if (code == 2'd2 && m_rows < H) begin
      b = m_sel ? 21'h080000 : 21'h0;
      for (int k = 0; k < W2; k++)
        sb.push_back('{b + 21'(m_rows * W2 + k), pix(9'(k))});
      m_rows++;
      rs_cyc = cyc;
    end else if (code == 2'd3 && m_rows == H) begin
      m_sel = ~m_sel;
      m_frame = 0;
    end else begin
      m_frame = 0;
    end
  endtask

  // monitor
  bit prev_wr = 0;
  bit prev_rdy = 0;
  int run = 0;
  always @(negedge clk) begin
    wr_t e;
    if (!reset_n) begin
      prev_wr = 0;
      prev_rdy = 0;
      run = 0;
    end else begin
      if (cmd_rdy) chk("rdy_pulse", 64'(prev_rdy), 0);
      if (frame_done) done_cnt++;
      if (wr_en) begin
        wr_cnt++;
        if (!prev_wr) chk("wr_latency", 64'(cyc - rs_cyc), D);
        run++;
        if (sb.size() == 0) begin
          chk("unexpected_wr", 64'(wr_addr), 64'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(e.addr));
          chk("wr_data", 64'(wr_data), 64'(e.data));
        end
      end else if (prev_wr) begin
        chk("row_run_len", 64'(run), W2);
        run = 0;
      end
      prev_wr = wr_en;
      prev_rdy = cmd_rdy;
    end
  end

  task automatic send_cmd(input logic [1:0] code, output int lat);
    command_data = code;
    command_data_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cmd_rdy && lat < 2000);
    command_data_valid = 1'b0;
    if (cmd_rdy) model_accept(code);
    else chk("rdy_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_row(input int target);
    for (int t = 0; t < 2000 && row_count != 11'(target); t++)
      @(negedge clk);
    chk("row_done", 64'(row_count), 64'(target));
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_rdy"}, 64'(cmd_rdy), 0);
    chk({nm, "_maddr"}, 64'(mem_addr), 0);
    chk({nm, "_wr_en"}, 64'(wr_en), 0);
    chk({nm, "_wr_addr"}, 64'(wr_addr), 0);
    chk({nm, "_wr_data"}, 64'(wr_data), 0);
    chk({nm, "_sel"}, 64'(buffer_sel), 0);
    chk({nm, "_done"}, 64'(frame_done), 0);
    chk({nm, "_err"}, 64'(protocol_error), 0);
    chk({nm, "_rows"}, 64'(row_count), 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_zero_outs("reset");
    sb.delete();
    m_frame = 0;
    m_sel = 0;
    m_rows = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] code;
    int rep;
    bit wait_row;
    bit err;
    int done;
    bit sel;
    int rows;
  } step_t;

  step_t tbl[14];

  initial begin
    int lat;
    int d0;
    int w0;
    int last;
    tbl[0]  = '{2'd1, 1,  0, 0, 0, 0, 0};
    tbl[1]  = '{2'd2, H,  1, 0, 0, 0, H};
    tbl[2]  = '{2'd3, 1,  0, 0, 1, 1, H};
    tbl[3]  = '{2'd1, 1,  0, 0, 0, 1, 0};
    tbl[4]  = '{2'd2, H,  1, 0, 0, 1, H};
    tbl[5]  = '{2'd3, 1,  0, 0, 1, 0, H};
    tbl[6]  = '{2'd1, 1,  0, 0, 0, 0, 0};
    tbl[7]  = '{2'd2, 5,  1, 0, 0, 0, 5};
    tbl[8]  = '{2'd3, 1,  0, 1, 0, 0, 5};
    tbl[9]  = '{2'd1, 1,  0, 1, 0, 0, 0};
    tbl[10] = '{2'd2, H,  1, 1, 0, 0, H};
    tbl[11] = '{2'd3, 1,  0, 1, 1, 1, H};
    tbl[12] = '{2'd0, 1,  0, 1, 0, 1, H};
    tbl[13] = '{2'd2, 1,  0, 1, 0, 1, H};

    #1 chk_zero_outs("por");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (tbl[s]) begin
      d0 = done_cnt;
      for (int n = 0; n < tbl[s].rep; n++) begin
        send_cmd(tbl[s].code, lat);
        chk($sformatf("s%0d_rdy_lat", s), 64'(lat), 1);
        if (tbl[s].wait_row) wait_row(n + 1);
      end
      chk($sformatf("s%0d_err", s), 64'(protocol_error),
          64'(tbl[s].err));
      chk($sformatf("s%0d_done", s), 64'(done_cnt - d0),
          64'(tbl[s].done));
      chk($sformatf("s%0d_sel", s), 64'(buffer_sel), 64'(tbl[s].sel));
      chk($sformatf("s%0d_rows", s), 64'(row_count), 64'(tbl[s].rows));
    end

    // bad codes in IDLE from a clean reset
    do_reset();
    w0 = wr_cnt;
    send_cmd(2'd0, lat);
    chk("code0_lat", 64'(lat), 1);
    chk("code0_err", 64'(protocol_error), 1);
    send_cmd(2'd2, lat);
    chk("idle_rs_lat", 64'(lat), 1);
    repeat (W2 + 20) @(negedge clk);
    chk("idle_no_wr", 64'(wr_cnt - w0), 0);

    // reset in the middle of row 3
    do_reset();
    send_cmd(2'd1, lat);
    for (int r = 0; r < 3; r++) begin
      send_cmd(2'd2, lat);
      wait_row(r + 1);
    end
    send_cmd(2'd2, lat);
    for (int t = 0; t < 1000 && mem_addr != 9'd100; t++)
      @(negedge clk);
    chk("mid_col", 64'(mem_addr), 100);
    #2 reset_n = 1'b0;
    #1 chk_zero_outs("mid_reset");
    sb.delete();
    m_frame = 0;
    m_sel = 0;
    m_rows = 0;
    w0 = wr_cnt;
    repeat (20) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_wr", 64'(wr_cnt - w0), 0);

    // clean frame into buffer 0, next command held through each row
    d0 = done_cnt;
    send_cmd(2'd1, lat);
    command_data = 2'd2;
    command_data_valid = 1'b1;
    last = 0;
    for (int r = 0; r < H; r++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!cmd_rdy && lat < 2000);
      if (!cmd_rdy) chk("held_timeout", 0, 1);
      else model_accept(2'd2);
      if (r > 0) chk("held_gap", 64'(cyc - last), W2 + D + 1);
      else chk("held_lat", 64'(lat), 1);
      last = cyc;
    end
    command_data_valid = 1'b0;
    wait_row(H);
    send_cmd(2'd3, lat);
    chk("final_done", 64'(done_cnt - d0), 1);
    chk("final_sel", 64'(buffer_sel), 1);
    chk("final_err", 64'(protocol_error), 0);
    repeat (10) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fb_frame_writer.md
Name: fb_frame_writer

Overview:
- Memory-clock-domain consumer for the frame command stream produced by the debug pattern generator and the camera path.
- Commands: 1 = FRAME_START, 2 = ROW_START, 3 = FRAME_END.
- Accepts commands through the valid/rdy handshake. On each ROW_START it fetches the row from the source row buffer through a fixed-latency read port and issues one word write per cycle toward the SDRAM framebuffer.
- Frames alternate between two buffers. The active buffer toggles only when a frame completes cleanly.

Parameters:
- FRAME_WIDTH, 640, pixels per row; must be even. A row is FRAME_WIDTH/2 32-bit words.
- FRAME_HEIGHT, 480, rows per frame.
- MEM_READ_DELAY, 6, clk cycles from mem_addr driven to the matching pixel_data valid.
- ADDR_WIDTH, 21, framebuffer word-address width.
- BUF1_BASE, 21'h080000, word base address of buffer 1. Buffer 0 base is 0.
- Derived: RA_W = $clog2(FRAME_WIDTH/2).

Ports:
- clk  in  1  memory clock
- reset_n  in  1  asynchronous active-low reset
- command_data_valid  in  1  source holds command valid until cmd_rdy is seen
- command_data  in  2  command code
- cmd_rdy  out  1  one-cycle accept pulse
- mem_addr  out  RA_W  row-buffer word address
- pixel_data  in  32  row-buffer read data; [15:0] = even pixel, [31:16] = odd pixel
- wr_en  out  1  framebuffer write strobe
- wr_addr  out  ADDR_WIDTH  framebuffer word address
- wr_data  out  32  framebuffer write data
- buffer_sel  out  1  buffer currently being written
- frame_done  out  1  one-cycle pulse on clean frame completion
- protocol_error  out  1  sticky error flag
- row_count  out  11  rows completed in the current frame

Behaviour:
- Reset is asynchronous active-low, clock is clk. All outputs reset to 0, the FSM resets to IDLE, and the delay pipeline is cleared.
- Reset mid-row: write activity stops in the cycle reset asserts, no further wr_en is issued, and buffer_sel returns to 0.
- Handshake:
  - In IDLE or WAIT_CMD, when command_data_valid is sampled high, the block captures command_data and asserts cmd_rdy for exactly the following cycle.
  - cmd_rdy is never asserted for two consecutive cycles.
  - Outside IDLE/WAIT_CMD (ROW_READ, ROW_DRAIN, ACCEPT), cmd_rdy stays 0 and the source must hold its command.
- FSM states: IDLE, ACCEPT, WAIT_CMD, ROW_READ, ROW_DRAIN.
  - IDLE: waits for a command. FRAME_START → ACCEPT, then row_count=0 and go to WAIT_CMD. Any other code → protocol_error=1, stay in IDLE.
  - WAIT_CMD, ROW_START with row_count < FRAME_HEIGHT: go to ROW_READ with column counter = 0.
  - WAIT_CMD, FRAME_END with row_count == FRAME_HEIGHT: pulse frame_done for one cycle, toggle buffer_sel, return to IDLE.
  - WAIT_CMD, any other command (FRAME_END early, ROW_START with row_count == FRAME_HEIGHT, FRAME_START, code 0): protocol_error=1, go to IDLE. buffer_sel does not toggle and no frame_done pulse is issued.
  - ROW_READ: drives mem_addr = 0, 1, …, FRAME_WIDTH/2-1 on consecutive cycles, then goes to ROW_DRAIN.
  - ROW_DRAIN: waits MEM_READ_DELAY cycles for the last read to return, increments row_count, returns to WAIT_CMD.
- Write timing:
  - A valid-tag shift register of depth MEM_READ_DELAY tracks outstanding reads.
  - When address k was driven MEM_READ_DELAY cycles earlier: wr_en=1, wr_data=pixel_data, wr_addr = base + row_count*(FRAME_WIDTH/2) + k.
  - base = 0 if buffer_sel == 0, otherwise BUF1_BASE. Arithmetic is ADDR_WIDTH wide and truncates on wrap.
  - Exactly FRAME_WIDTH/2 writes per row, all on contiguous cycles.
- mem_addr holds its last value when not reading and returns to 0 at the next ROW_READ entry.
- protocol_error is cleared only by reset.
- row_count saturates at FRAME_HEIGHT and is cleared at FRAME_START.

Test Plan:
1. Clean frame, FRAME_WIDTH=640, FRAME_HEIGHT=20, MEM_READ_DELAY=6, pixel_data = 10-bar pattern:
   - 1 FRAME_START, 20 ROW_START, 1 FRAME_END.
   - Each row: 320 contiguous wr_en cycles, first write 6 cycles after mem_addr=0.
   - wr_addr 0..6399, data matches bars.
   - One frame_done pulse, buffer_sel 0→1, protocol_error=0.
2. Second frame back-to-back:
   - wr_addr runs from 0x080000 to 0x080000+6399.
   - buffer_sel returns to 0 after frame_done.
3. Source holds command_data_valid through a row read:
   - cmd_rdy stays 0 until ROW_DRAIN ends.
   - cmd_rdy is a single-cycle pulse, one cycle after valid is sampled.
4. FRAME_END after 5 rows:
   - protocol_error=1, no frame_done, buffer_sel unchanged.
   - A following clean frame is written correctly; protocol_error stays 1.
5. Code 0 and a ROW_START in IDLE:
   - protocol_error=1, no wr_en.
   - cmd_rdy pulses once per command.
6. reset_n asserted at column 100 of row 3:
   - All outputs 0 immediately, no wr_en afterwards.
   - After release, a fresh FRAME_START frame completes cleanly into buffer 0.
